// File: rtl/loader_pkg.sv
// ============================================================================
// Module   : loader_pkg
// Brief    : Shared state encoding and frame geometry for the operand loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package loader_pkg;

    localparam int NUM_A     = 16;
    localparam int NUM_B     = 9;
    localparam int FRAME_LEN = NUM_A + NUM_B;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_CHECK = 2'd1,
        ST_ISSUE = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/loader_checksum.sv
// ============================================================================
// Module   : loader_checksum
// Brief    : Running XOR accumulator over a frame; clear restarts the sum and
//            may coincide with the first enabled byte of the next frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module loader_checksum #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_sum
);

    logic [DATA_W-1:0] r_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum <= '0;
        end else if (i_clear) begin
            r_sum <= i_en ? i_data : '0;
        end else if (i_en) begin
            r_sum <= r_sum ^ i_data;
        end
    end

    assign o_sum = r_sum;

endmodule

`default_nettype wire

// File: rtl/operand_loader.sv
// ============================================================================
// Module   : operand_loader
// Brief    : Streams a 4x4 A and 3x3 B operand frame byte-by-byte, then issues a
//            run pulse and waits for done_i. Optional macro LOADER_CHECKSUM_EN
//            adds a trailing XOR checksum byte.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_loader
    import loader_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  in_ready,
    input  logic                  done_i,
    output logic [16*DATA_W-1:0]  a_o,
    output logic [9*DATA_W-1:0]   b_o,
    output logic                  run,
    output logic                  busy,
    output logic                  err
);

    localparam logic [4:0] c_last_idx = 5'(FRAME_LEN - 1);
    localparam logic [4:0] c_num_a    = 5'(NUM_A);

    state_t            r_state;
    logic [4:0]        r_idx;
    logic              r_run;
    logic              r_busy;
    logic              r_ready;
    logic [DATA_W-1:0] r_a [NUM_A];
    logic [DATA_W-1:0] r_b [NUM_B];

    logic              w_accept;
    logic              w_load_wr;
    logic              w_issue_ok;
    logic [3:0]        w_b_idx;

    assign w_accept  = in_valid && r_ready;
    assign w_load_wr = w_accept && (r_state == ST_LOAD);
    assign w_b_idx   = 4'(r_idx - c_num_a);

`ifdef LOADER_CHECKSUM_EN
    logic              w_frame_start;
    logic [DATA_W-1:0] w_sum;

    // Restarting at index 0 discards whatever a failed or reset frame left.
    assign w_frame_start = (r_state == ST_LOAD) && (r_idx == 5'd0);

    loader_checksum #(
        .DATA_W (DATA_W)
    ) u_checksum (
        .clk     (clk),
        .rst     (reset),
        .i_clear (w_frame_start),
        .i_en    (w_load_wr),
        .i_data  (in_data),
        .o_sum   (w_sum)
    );

    assign w_issue_ok = (in_data == w_sum);
    // Combinational so the failure pulse lives strictly inside the CHECK cycle.
    assign err        = (r_state == ST_CHECK) && w_accept && !w_issue_ok;
`else
    assign w_issue_ok = 1'b1;
    assign err        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_LOAD;
            r_idx   <= '0;
            r_run   <= 1'b0;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_run <= 1'b0;
            case (r_state)
                ST_LOAD: begin
                    if (w_accept) begin
                        if (r_idx == c_last_idx) begin
                            r_idx <= '0;
`ifdef LOADER_CHECKSUM_EN
                            r_state <= ST_CHECK;
`else
                            r_state <= ST_ISSUE;
                            r_run   <= 1'b1;
                            r_busy  <= 1'b1;
                            r_ready <= 1'b0;
`endif
                        end else begin
                            r_idx <= r_idx + 5'd1;
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (w_accept) begin
                        r_idx <= '0;
                        if (w_issue_ok) begin
                            r_state <= ST_ISSUE;
                            r_run   <= 1'b1;
                            r_busy  <= 1'b1;
                            r_ready <= 1'b0;
                        end else begin
                            r_state <= ST_LOAD;
                        end
                    end
                end
`endif
                ST_ISSUE: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (done_i) begin
                        r_state <= ST_LOAD;
                        r_idx   <= '0;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_LOAD;
                    r_idx   <= '0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_A; k++) r_a[k] <= '0;
            for (int j = 0; j < NUM_B; j++) r_b[j] <= '0;
        end else if (w_load_wr) begin
            if (r_idx < c_num_a) begin
                r_a[r_idx[3:0]] <= in_data;
            end else begin
                r_b[w_b_idx] <= in_data;
            end
        end
    end

    for (genvar k = 0; k < NUM_A; k++) begin : g_pack_a
        assign a_o[DATA_W*k +: DATA_W] = r_a[k];
    end

    for (genvar j = 0; j < NUM_B; j++) begin : g_pack_b
        assign b_o[DATA_W*j +: DATA_W] = r_b[j];
    end

    assign in_ready = r_ready;
    assign run      = r_run;
    assign busy     = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_operand_loader.sv
// ============================================================================
// Module   : tb_operand_loader
// Brief    : Self-checking bench for operand_loader; honours LOADER_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_operand_loader;
    import loader_pkg::*;

    localparam int DATA_W = 8;
`ifdef LOADER_CHECKSUM_EN
    localparam int TB_FRAME = FRAME_LEN + 1;
`else
    localparam int TB_FRAME = FRAME_LEN;
`endif

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic [DATA_W-1:0]    in_data;
    logic                 in_ready;
    logic                 done_i;
    logic [16*DATA_W-1:0] a_o;
    logic [9*DATA_W-1:0]  b_o;
    logic                 run;
    logic                 busy;
    logic                 err;

    always #5 clk = ~clk;

    operand_loader #(.DATA_W(DATA_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .done_i   (done_i),
        .a_o      (a_o),
        .b_o      (b_o),
        .run      (run),
        .busy     (busy),
        .err      (err)
    );

    int errors = 0, checks = 0;
    int cyc = 0, run_cnt = 0, run_cyc = -1, err_cnt = 0, last_acc = -1;
    logic [7:0] frame [32];
    logic [7:0] m_ops [FRAME_LEN];   // reference operand store, element order

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (run) begin
            run_cnt++;
            run_cyc = cyc;
        end
        if (err) err_cnt++;
    end

    typedef struct {
        int         gap;        // 0: continuous, 1: alternate, 2: random valid
        bit         rnd;
        logic [7:0] base;
        logic [7:0] step;
        bit         pre_reset;
        bit         done_load;
        logic [7:0] exp_a0;
        logic [7:0] exp_b8;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] pack_a();
        logic [127:0] r = '0;
        for (int k = 0; k < NUM_A; k++) r[8*k +: 8] = m_ops[k];
        return r;
    endfunction

    function automatic logic [127:0] pack_b();
        logic [127:0] r = '0;
        for (int j = 0; j < NUM_B; j++) r[8*j +: 8] = m_ops[NUM_A + j];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        done_i = 1'b0;
        tick();
        reset = 1'b0;
        for (int k = 0; k < FRAME_LEN; k++) m_ops[k] = '0;
    endtask

    // Push count bytes of frame[]; the model records each accepted operand byte.
    task automatic send_bytes(input int count, input int gap, input bit dl);
        int  n = 0;
        int  guard = 0;
        bit  v;
        bit  took;
        while (n < count && guard < 400) begin
            v = (gap == 0) ? 1'b1 : (gap == 1) ? (guard % 2 == 0) : 1'($urandom_range(0, 1));
            in_valid = v;
            in_data  = v ? frame[n] : 8'($urandom);
            done_i   = dl;
            took     = v && in_ready;
            if (took) last_acc = cyc;
            tick();
            if (took) begin
                if (n < FRAME_LEN) m_ops[n] = frame[n];
                n++;
            end
            guard++;
        end
        in_valid = 1'b0;
        done_i   = 1'b0;
        chk("bytes_accepted", 128'(n), 128'(count));
    endtask

    task automatic fill_checksum(input bit good);
        logic [7:0] x = '0;
        for (int k = 0; k < FRAME_LEN; k++) x ^= frame[k];
        frame[FRAME_LEN] = good ? x : ~x;
    endtask

    task automatic hold_and_release();
        int rdy_hi = 0, busy_lo = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            in_data  = 8'hFF;
            if (in_ready) rdy_hi++;
            if (!busy) busy_lo++;
            tick();
        end
        in_valid = 1'b0;
        chk("wait_ready_low", 128'(rdy_hi), 128'd0);
        chk("wait_busy_high", 128'(busy_lo), 128'd0);
        chk("wait_hold_a", a_o, pack_a());
        chk("wait_hold_b", b_o, pack_b());
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        chk("done_to_load_ready", 128'(in_ready), 128'd1);
        chk("done_to_load_busy", 128'(busy), 128'd0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; done_i = 1'b0;
        tick();
        do_reset();
        chk("reset_a", a_o, 128'd0);
        chk("reset_b", b_o, 128'd0);
        chk("reset_outs", {run, busy, err, in_ready}, 4'b0001);

        vecs[0] = '{0, 0, 8'h01, 8'h01, 0, 0, 8'h01, 8'h19};
        vecs[1] = '{1, 0, 8'h01, 8'h01, 0, 0, 8'h01, 8'h19};
        vecs[2] = '{0, 0, 8'hAA, 8'h00, 1, 0, 8'hAA, 8'hAA};
        vecs[3] = '{2, 1, 8'h00, 8'h00, 0, 1, 8'h00, 8'h00};
        vecs[4] = '{0, 0, 8'hF0, 8'h03, 0, 1, 8'hF0, 8'h38};
        vecs[5] = '{2, 1, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00};

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].pre_reset) begin
                for (int k = 0; k < 7; k++) frame[k] = 8'($urandom);
                send_bytes(7, 0, 1'b0);
                chk("partial_a", a_o, pack_a());
                do_reset();
                chk("reset_mid_a", a_o, 128'd0);
                chk("reset_mid_ready", 128'(in_ready), 128'd1);
            end
            for (int k = 0; k < FRAME_LEN; k++)
                frame[k] = vecs[i].rnd ? 8'($urandom) : 8'(vecs[i].base + 8'(k) * vecs[i].step);
`ifdef LOADER_CHECKSUM_EN
            fill_checksum(1'b1);
`endif
            run_cnt = 0; err_cnt = 0;
            send_bytes(TB_FRAME, vecs[i].gap, vecs[i].done_load);
            tick(); tick();
            chk("run_once", 128'(run_cnt), 128'd1);
            chk("run_latency", 128'(run_cyc), 128'(last_acc + 1));
            chk("busy_in_wait", 128'(busy), 128'd1);
            chk("frame_a", a_o, pack_a());
            chk("frame_b", b_o, pack_b());
            chk("no_err", 128'(err_cnt), 128'd0);
            if (!vecs[i].rnd) begin
                chk("a_elem0", 128'(a_o[7:0]), 128'(vecs[i].exp_a0));
                chk("b_elem8", 128'(b_o[71:64]), 128'(vecs[i].exp_b8));
            end
            hold_and_release();
            chk("run_still_once", 128'(run_cnt), 128'd1);
        end

        // Reset while parked in WAIT.
        for (int k = 0; k < FRAME_LEN; k++) frame[k] = 8'($urandom);
`ifdef LOADER_CHECKSUM_EN
        fill_checksum(1'b1);
`endif
        send_bytes(TB_FRAME, 0, 1'b0);
        tick(); tick();
        chk("pre_reset_busy", 128'(busy), 128'd1);
        do_reset();
        chk("reset_wait_a", a_o, 128'd0);
        chk("reset_wait_b", b_o, 128'd0);
        chk("reset_wait_outs", {run, busy, err, in_ready}, 4'b0001);

`ifdef LOADER_CHECKSUM_EN
        for (int k = 0; k < FRAME_LEN; k++) frame[k] = 8'(k + 1);
        frame[FRAME_LEN] = 8'h00;
        run_cnt = 0; err_cnt = 0;
        send_bytes(TB_FRAME, 0, 1'b0);
        tick();
        chk("bad_sum_err", 128'(err_cnt), 128'd1);
        chk("bad_sum_norun", 128'(run_cnt), 128'd0);
        chk("bad_sum_ready", {busy, in_ready}, 2'b01);
        frame[FRAME_LEN] = 8'h01;
        send_bytes(TB_FRAME, 1, 1'b0);
        tick(); tick();
        chk("good_sum_run", 128'(run_cnt), 128'd1);
        chk("good_sum_err", 128'(err_cnt), 128'd1);
        chk("good_sum_a", a_o, pack_a());
        chk("good_sum_b", b_o, pack_b());
        hold_and_release();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
